// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// FSM state encoding and the per-stage stall/flush vector type.
package hazard_pkg;

  localparam int STG_PC    = 0;
  localparam int STG_IFID  = 1;
  localparam int STG_IDEX  = 2;
  localparam int STG_EXMEM = 3;
  localparam int STG_MEMWB = 4;
  localparam int NSTAGE    = 5;

  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_EX_BUSY = 2'd1,
    HZ_DISCARD = 2'd2
  } hz_state_e;

  typedef logic [NSTAGE-1:0] stage_vec_t;

  function automatic stage_vec_t stg(input int idx);
    stage_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Stall/flush patterns shared by several arbitration outcomes
  localparam stage_vec_t SV_ALL      = '1;
  localparam stage_vec_t SV_EX_STALL = stg(STG_PC) | stg(STG_IFID) | stg(STG_IDEX);
  localparam stage_vec_t SV_EX_FLUSH = stg(STG_EXMEM);
  localparam stage_vec_t SV_BR_FLUSH = stg(STG_IFID) | stg(STG_IDEX);
  localparam stage_vec_t SV_LU_STALL = stg(STG_PC) | stg(STG_IFID);
  localparam stage_vec_t SV_LU_FLUSH = stg(STG_IDEX);
  localparam stage_vec_t SV_IF_STALL = stg(STG_PC);
  localparam stage_vec_t SV_IF_FLUSH = stg(STG_IFID);

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection between the load in EX and the
// instruction in ID; legacy mode bubbles after every load.
module load_use_detect #(
  parameter int REG_AW         = 5,
  parameter int LOAD_USE_CHECK = 1
) (
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_reg_w,
  input  logic              ex_mem_r,
  output logic              hazard
);

  logic rs1_hit;
  logic rs2_hit;
  logic true_dep;

  assign rs1_hit  = id_rs1_used && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit  = id_rs2_used && (id_rs2_addr == ex_rd_addr);
  // x0 is never a real destination, so a load to x0 creates no dependency
  assign true_dep = ex_mem_r && ex_reg_w && (ex_rd_addr != '0) && (rs1_hit || rs2_hit);

  assign hazard = (LOAD_USE_CHECK != 0) ? true_dep : ex_mem_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage core: arbitrates memory waits,
// multi-cycle EX ops, taken branches and load-use, and counts stall/flush cycles.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW         = 5,
  parameter int EX_LAT         = 4,
  parameter int LOAD_USE_CHECK = 1,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_reg_w,
  input  logic              ex_mem_r,
  input  logic              ex_multi,
  input  logic              branch_taken,
  input  logic              im_wait,
  input  logic              dm_wait,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic              ex_done,
  output logic              im_discard,
  output logic [1:0]        hz_state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // The RUN cycle that accepts the op is the first of its EX_LAT cycles
  localparam logic [3:0] CNT_LOAD = 4'(EX_LAT - 1);

  hz_state_e        state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  stage_vec_t       stall_c, flush_c;
  logic             ex_done_c, im_discard_c;
  logic             lu_hazard;

  load_use_detect #(
    .REG_AW         (REG_AW),
    .LOAD_USE_CHECK (LOAD_USE_CHECK)
  ) u_lud (
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd_addr  (ex_rd_addr),
    .ex_reg_w    (ex_reg_w),
    .ex_mem_r    (ex_mem_r),
    .hazard      (lu_hazard)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_c      = '0;
    flush_c      = '0;
    ex_done_c    = 1'b0;
    im_discard_c = 1'b0;
    if (dm_wait) begin
      stall_c = SV_ALL;
    end else begin
      case (state_q)
        HZ_EX_BUSY: begin
          // cnt holds the EX cycles still to go, including this one
          if (cnt_q > 4'd1) begin
            stall_c = SV_EX_STALL;
            flush_c = SV_EX_FLUSH;
            cnt_d   = cnt_q - 4'd1;
          end else begin
            ex_done_c = 1'b1;
            cnt_d     = '0;
            state_d   = HZ_RUN;
          end
        end
        HZ_DISCARD: begin
          stall_c      = SV_IF_STALL;
          flush_c      = SV_IF_FLUSH;
          im_discard_c = 1'b1;
          if (!im_wait) state_d = HZ_RUN;
        end
        default: begin
          if (branch_taken) begin
            flush_c = SV_BR_FLUSH;
            if (im_wait) state_d = HZ_DISCARD;
          end else if (ex_multi) begin
            stall_c = SV_EX_STALL;
            flush_c = SV_EX_FLUSH;
            cnt_d   = CNT_LOAD;
            state_d = HZ_EX_BUSY;
          end else if (lu_hazard) begin
            stall_c = SV_LU_STALL;
            flush_c = SV_LU_FLUSH;
          end else if (im_wait) begin
            stall_c = SV_IF_STALL;
            flush_c = SV_IF_FLUSH;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HZ_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (|stall_c) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (|flush_c) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  // Outputs are forced quiet while reset is held, whatever the inputs do
  assign stall      = rst_n ? stall_c : '0;
  assign flush      = rst_n ? flush_c : '0;
  assign ex_done    = rst_n & ex_done_c;
  assign im_discard = rst_n & im_discard_c;
  assign hz_state   = state_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a checking instance with 4-bit counters
// and a legacy-mode instance sharing the same stimulus.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       id_rs1_used, id_rs2_used, ex_reg_w, ex_mem_r, ex_multi;
  logic       branch_taken, im_wait, dm_wait;

  logic [4:0] stall, flush, l_stall, l_flush;
  logic       ex_done, im_discard, l_ex_done, l_im_discard;
  logic [1:0] hz_state, l_hz_state;
  logic [3:0] stall_cnt, flush_cnt, l_stall_cnt, l_flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .EX_LAT(4), .LOAD_USE_CHECK(1), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_addr(ex_rd_addr), .ex_reg_w(ex_reg_w), .ex_mem_r(ex_mem_r),
    .ex_multi(ex_multi), .branch_taken(branch_taken),
    .im_wait(im_wait), .dm_wait(dm_wait),
    .stall(stall), .flush(flush), .ex_done(ex_done), .im_discard(im_discard),
    .hz_state(hz_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .EX_LAT(4), .LOAD_USE_CHECK(0), .CNT_W(4)) u_leg (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_addr(ex_rd_addr), .ex_reg_w(ex_reg_w), .ex_mem_r(ex_mem_r),
    .ex_multi(ex_multi), .branch_taken(branch_taken),
    .im_wait(im_wait), .dm_wait(dm_wait),
    .stall(l_stall), .flush(l_flush), .ex_done(l_ex_done), .im_discard(l_im_discard),
    .hz_state(l_hz_state), .stall_cnt(l_stall_cnt), .flush_cnt(l_flush_cnt)
  );

  // stall and flush must never target the same stage
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_checks++;
      if (((stall & flush) | (l_stall & l_flush)) !== 5'b0) begin
        n_fail++;
        $display("FAIL overlap: stall=%b flush=%b l_stall=%b l_flush=%b required no common bit",
                 stall, flush, l_stall, l_flush);
      end
    end
  end

  task automatic idle();
    id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
    id_rs1_used = 0; id_rs2_used = 0; ex_reg_w = 0; ex_mem_r = 0;
    ex_multi = 0; branch_taken = 0; im_wait = 0; dm_wait = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    im_wait = 1; dm_wait = 1; ex_multi = 1; branch_taken = 1;
    @(negedge clk);
    n_checks++;
    if ({stall, flush, ex_done, im_discard} !== 12'b0) begin
      n_fail++; $display("FAIL reset_outputs: got stall=%b flush=%b done=%b disc=%b required all 0",
                         stall, flush, ex_done, im_discard);
    end
    n_checks++;
    if (hz_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d required 0", hz_state);
    end
    cyc();
    n_checks++;
    if ({stall_cnt, flush_cnt} !== 8'b0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d required 0/0", stall_cnt, flush_cnt);
    end
    idle();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_load_use();
    // lw x5 in EX, add x6,x5,x1 in ID
    cyc();
    ex_mem_r = 1; ex_reg_w = 1; ex_rd_addr = 5'd5;
    id_rs1_addr = 5'd5; id_rs2_addr = 5'd1; id_rs1_used = 1; id_rs2_used = 1;
    @(negedge clk);
    n_checks++;
    if (stall !== 5'b00011 || flush !== 5'b00100) begin
      n_fail++; $display("FAIL lu_match: got stall=%b flush=%b required 00011/00100", stall, flush);
    end
    n_checks++;
    if (l_stall !== 5'b00011 || l_flush !== 5'b00100) begin
      n_fail++; $display("FAIL lu_match_legacy: got stall=%b flush=%b required 00011/00100", l_stall, l_flush);
    end
    cyc();
    idle();
    @(negedge clk);
    n_checks++;
    if (stall !== 5'b0 || flush !== 5'b0) begin
      n_fail++; $display("FAIL lu_one_bubble: got stall=%b flush=%b required 0/0", stall, flush);
    end
    // rs unrelated: add x6,x7,x1
    cyc();
    ex_mem_r = 1; ex_reg_w = 1; ex_rd_addr = 5'd5;
    id_rs1_addr = 5'd7; id_rs2_addr = 5'd1; id_rs1_used = 1; id_rs2_used = 1;
    @(negedge clk);
    n_checks++;
    if (stall !== 5'b0 || flush !== 5'b0) begin
      n_fail++; $display("FAIL lu_unrelated: got stall=%b flush=%b required 0/0", stall, flush);
    end
    n_checks++;
    if (l_stall !== 5'b00011 || l_flush !== 5'b00100) begin
      n_fail++; $display("FAIL lu_unrelated_legacy: got stall=%b flush=%b required 00011/00100", l_stall, l_flush);
    end
    // match only on an unused rs2 field
    cyc();
    id_rs1_addr = 5'd7; id_rs2_addr = 5'd5; id_rs2_used = 0;
    @(negedge clk);
    n_checks++;
    if (stall !== 5'b0) begin
      n_fail++; $display("FAIL lu_rs2_unused: got stall=%b required 00000", stall);
    end
    // rs2 used match
    cyc();
    id_rs2_used = 1;
    @(negedge clk);
    n_checks++;
    if (stall !== 5'b00011) begin
      n_fail++; $display("FAIL lu_rs2_match: got stall=%b required 00011", stall);
    end
    // load to x0 never creates a dependency
    cyc();
    ex_rd_addr = 5'd0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
    @(negedge clk);
    n_checks++;
    if (stall !== 5'b0) begin
      n_fail++; $display("FAIL lu_x0: got stall=%b required 00000", stall);
    end
    cyc();
    idle();
  endtask

  task automatic test_multi();
    cyc();
    ex_multi = 1;
    @(negedge clk);
    n_checks++;
    if (stall !== 5'b00111 || flush !== 5'b01000 || ex_done !== 1'b0) begin
      n_fail++; $display("FAIL multi_c1: got stall=%b flush=%b done=%b required 00111/01000/0", stall, flush, ex_done);
    end
    for (int c = 2; c <= 3; c++) begin
      cyc();
      @(negedge clk);
      n_checks++;
      if (stall !== 5'b00111 || hz_state !== 2'd1 || ex_done !== 1'b0) begin
        n_fail++; $display("FAIL multi_busy c%0d: got stall=%b state=%0d done=%b required 00111/1/0",
                           c, stall, hz_state, ex_done);
      end
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if (ex_done !== 1'b1 || stall !== 5'b0 || flush !== 5'b0 || l_ex_done !== 1'b1) begin
      n_fail++; $display("FAIL multi_done: got done=%b stall=%b flush=%b l_done=%b required 1/0/0/1",
                         ex_done, stall, flush, l_ex_done);
    end
    cyc();
    ex_multi = 0;
    @(negedge clk);
    n_checks++;
    if (ex_done !== 1'b0 || hz_state !== 2'd0) begin
      n_fail++; $display("FAIL multi_after: got done=%b state=%0d required 0/0", ex_done, hz_state);
    end
    // same op with two data-memory wait cycles in the middle
    cyc();
    ex_multi = 1;
    cyc();
    @(negedge clk);
    n_checks++;
    if (hz_state !== 2'd1 || ex_done !== 1'b0) begin
      n_fail++; $display("FAIL multi_dm_c2: got state=%0d done=%b required 1/0", hz_state, ex_done);
    end
    for (int c = 3; c <= 4; c++) begin
      cyc();
      dm_wait = 1;
      @(negedge clk);
      n_checks++;
      if (stall !== 5'b11111 || flush !== 5'b0 || ex_done !== 1'b0) begin
        n_fail++; $display("FAIL multi_dm_wait c%0d: got stall=%b flush=%b done=%b required 11111/0/0",
                           c, stall, flush, ex_done);
      end
    end
    cyc();
    dm_wait = 0;
    @(negedge clk);
    n_checks++;
    if (stall !== 5'b00111 || ex_done !== 1'b0) begin
      n_fail++; $display("FAIL multi_dm_c5: got stall=%b done=%b required 00111/0", stall, ex_done);
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if (ex_done !== 1'b1 || stall !== 5'b0) begin
      n_fail++; $display("FAIL multi_dm_c6: got done=%b stall=%b required 1/00000", ex_done, stall);
    end
    cyc();
    ex_multi = 0;
    @(negedge clk);
    n_checks++;
    if (hz_state !== 2'd0 || ex_done !== 1'b0) begin
      n_fail++; $display("FAIL multi_dm_after: got state=%0d done=%b required 0/0", hz_state, ex_done);
    end
  endtask

  task automatic test_branch_discard();
    cyc();
    branch_taken = 1; im_wait = 1;
    @(negedge clk);
    n_checks++;
    if (flush !== 5'b00110 || stall !== 5'b0 || im_discard !== 1'b0) begin
      n_fail++; $display("FAIL br_c1: got flush=%b stall=%b disc=%b required 00110/0/0", flush, stall, im_discard);
    end
    for (int c = 2; c <= 3; c++) begin
      cyc();
      branch_taken = 0;
      @(negedge clk);
      n_checks++;
      if (im_discard !== 1'b1 || hz_state !== 2'd2 || stall !== 5'b00001 || flush !== 5'b00010) begin
        n_fail++; $display("FAIL br_discard c%0d: got disc=%b state=%0d stall=%b flush=%b required 1/2/00001/00010",
                           c, im_discard, hz_state, stall, flush);
      end
    end
    cyc();
    im_wait = 0;
    @(negedge clk);
    n_checks++;
    if (im_discard !== 1'b1 || hz_state !== 2'd2 || l_im_discard !== 1'b1) begin
      n_fail++; $display("FAIL br_drop: got disc=%b state=%0d l_disc=%b required 1/2/1", im_discard, hz_state, l_im_discard);
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if (im_discard !== 1'b0 || hz_state !== 2'd0 || stall !== 5'b0) begin
      n_fail++; $display("FAIL br_back_run: got disc=%b state=%0d stall=%b required 0/0/0", im_discard, hz_state, stall);
    end
  endtask

  task automatic test_branch_loaduse();
    cyc();
    branch_taken = 1;
    ex_mem_r = 1; ex_reg_w = 1; ex_rd_addr = 5'd5;
    id_rs1_addr = 5'd5; id_rs1_used = 1;
    @(negedge clk);
    n_checks++;
    if (flush !== 5'b00110 || stall !== 5'b0 || l_flush !== 5'b00110 || l_stall !== 5'b0) begin
      n_fail++; $display("FAIL br_lu: got flush=%b stall=%b l_flush=%b l_stall=%b required 00110/0/00110/0",
                         flush, stall, l_flush, l_stall);
    end
    cyc();
    idle();
    @(negedge clk);
    n_checks++;
    if (hz_state !== 2'd0 || l_hz_state !== 2'd0) begin
      n_fail++; $display("FAIL br_lu_state: got %0d/%0d required 0/0", hz_state, l_hz_state);
    end
  endtask

  task automatic test_reset_mid_op();
    cyc();
    ex_multi = 1;
    cyc();
    cyc();
    // now in EX_BUSY with two cycles left
    rst_n = 0; im_wait = 1;
    #1;
    n_checks++;
    if ({stall, flush, ex_done, im_discard} !== 12'b0 || hz_state !== 2'd0) begin
      n_fail++; $display("FAIL rst_busy: got stall=%b flush=%b done=%b state=%0d required all 0",
                         stall, flush, ex_done, hz_state);
    end
    cyc();
    idle();
    rst_n = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (ex_done !== 1'b0 || hz_state !== 2'd0) begin
        n_fail++; $display("FAIL rst_busy_after c%0d: got done=%b state=%0d required 0/0", c, ex_done, hz_state);
      end
      cyc();
    end
    branch_taken = 1; im_wait = 1;
    cyc();
    branch_taken = 0;
    rst_n = 0;
    #1;
    n_checks++;
    if (im_discard !== 1'b0 || hz_state !== 2'd0) begin
      n_fail++; $display("FAIL rst_disc: got disc=%b state=%0d required 0/0", im_discard, hz_state);
    end
    cyc();
    idle();
    rst_n = 1;
    @(negedge clk);
    n_checks++;
    if (im_discard !== 1'b0 || hz_state !== 2'd0) begin
      n_fail++; $display("FAIL rst_disc_after: got disc=%b state=%0d required 0/0", im_discard, hz_state);
    end
  endtask

  task automatic test_counter_wrap();
    cyc();
    rst_n = 0;
    idle();
    cyc();
    rst_n = 1;
    for (int i = 1; i <= 17; i++) begin
      cyc();
      im_wait = 1;
      @(negedge clk);
      if (i == 17) begin
        n_checks++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
          n_fail++; $display("FAIL cnt_wrap16: got %0d/%0d required 0/0", stall_cnt, flush_cnt);
        end
      end
    end
    cyc();
    idle();
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== 4'd1 || flush_cnt !== 4'd1 || l_stall_cnt !== 4'd1 || l_flush_cnt !== 4'd1) begin
      n_fail++; $display("FAIL cnt_wrap17: got %0d/%0d l %0d/%0d required 1/1 1/1",
                         stall_cnt, flush_cnt, l_stall_cnt, l_flush_cnt);
    end
    cyc();
    branch_taken = 1;
    cyc();
    idle();
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== 4'd1 || flush_cnt !== 4'd2) begin
      n_fail++; $display("FAIL cnt_flush_only: got %0d/%0d required 1/2", stall_cnt, flush_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_multi();
    test_branch_discard();
    test_branch_loaduse();
    test_reset_mid_op();
    test_counter_wrap();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
